// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolve controller.
// Counter helper lives here so the BHT and any future users agree on it.
package branch_resolve_ctrl_pkg;

    typedef enum logic [0:0] {
        S_IDLE,
        S_REDIRECT
    } bru_state_t;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_WEAK_NT = 2'b01;
    localparam int       PC_STEP     = 4;

    function automatic bht_cnt_t bht_next(bht_cnt_t c, logic taken);
        bht_cnt_t n;
        n = c;
        if (taken) begin
            if (c != 2'b11) n = c + 2'b01;
        end else begin
            if (c != 2'b00) n = c - 2'b01;
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Redirect handshake between the branch resolve controller and fetch.
// master = resolve controller, slave = fetch.
interface branch_resolve_ctrl_if #(
    parameter int XLEN = 32
);

    logic            o_redirect_valid;
    logic [XLEN-1:0] o_redirect_pc;
    logic            i_redirect_ready;

    modport master (
        output o_redirect_valid,
        output o_redirect_pc,
        input  i_redirect_ready
    );

    modport slave (
        input  o_redirect_valid,
        input  o_redirect_pc,
        output i_redirect_ready
    );

endinterface

// File: rtl/branch_resolve_ctrl_bht_2bit.sv
// Branch history table of 2-bit saturating counters.
// Lookup is combinational and sees the pre-update value on a same-index write.
module bht_2bit
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int IDX_LSB = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_rd_pc,
    output logic            o_rd_taken,
    input  logic            i_wr_en,
    input  logic [XLEN-1:0] i_wr_pc,
    input  logic            i_wr_taken
);

    localparam int IW = $clog2(ENTRIES);

    bht_cnt_t        cnt_q [ENTRIES];
    logic [IW-1:0]   rd_idx;
    logic [IW-1:0]   wr_idx;
    logic            unused_pc;

    assign rd_idx     = i_rd_pc[IDX_LSB +: IW];
    assign wr_idx     = i_wr_pc[IDX_LSB +: IW];
    assign o_rd_taken = cnt_q[rd_idx][1];
    assign unused_pc  = ^{i_rd_pc, i_wr_pc};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= BHT_WEAK_NT;
            end
        end else if (i_wr_en) begin
            cnt_q[wr_idx] <= bht_next(cnt_q[wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution at EX: mispredict detection, fetch redirect, BHT update.
// Define BRANCH_STATS_EN to build the resolved/mispredict counters.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BHT_IDX_LSB = 2,
    parameter int STAT_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [XLEN-1:0]       i_if_pc,
    output logic                  o_if_pred_taken,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_is_jump,
    input  logic                  i_cmp_branch,
    input  logic [XLEN-1:0]       i_ex_pc,
    input  logic [XLEN-1:0]       i_ex_target,
    input  logic [XLEN-1:0]       i_ex_pred_pc,
    branch_resolve_ctrl_if.master redir,
    output logic                  o_flush,
    output logic                  o_stall,
    output logic [STAT_W-1:0]     o_stat_branches,
    output logic [STAT_W-1:0]     o_stat_mispred
);

    bru_state_t      state_q;
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic            flush_q;
    logic            stall_q;

    logic            taken;
    logic [XLEN-1:0] next_pc;
    logic            mispred;
    logic            resolve;

    assign taken   = i_ex_is_jump | i_cmp_branch;
    assign next_pc = taken ? i_ex_target
                           : i_ex_pc + XLEN'(PC_STEP);
    assign mispred = next_pc != i_ex_pred_pc;
    // EX is frozen while a redirect is outstanding.
    assign resolve = i_ex_valid && (state_q == S_IDLE);

    bht_2bit #(
        .XLEN    (XLEN),
        .ENTRIES (BHT_ENTRIES),
        .IDX_LSB (BHT_IDX_LSB)
    ) u_bht (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rd_pc    (i_if_pc),
        .o_rd_taken (o_if_pred_taken),
        .i_wr_en    (resolve && !i_ex_is_jump),
        .i_wr_pc    (i_ex_pc),
        .i_wr_taken (i_cmp_branch)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            pc_q    <= '0;
            flush_q <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    flush_q <= 1'b0;
                    if (resolve && mispred) begin
                        state_q <= S_REDIRECT;
                        valid_q <= 1'b1;
                        pc_q    <= next_pc;
                        flush_q <= 1'b1;
                        stall_q <= 1'b1;
                    end
                end
                S_REDIRECT: begin
                    flush_q <= 1'b0;
                    if (redir.i_redirect_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        stall_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign redir.o_redirect_valid = valid_q;
    assign redir.o_redirect_pc    = pc_q;
    assign o_flush                = flush_q;
    assign o_stall                = stall_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] br_q;
    logic [STAT_W-1:0] mp_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            br_q <= '0;
            mp_q <= '0;
        end else if (resolve) begin
            if (br_q != '1) br_q <= br_q + 1'b1;
            if (mispred && mp_q != '1) mp_q <= mp_q + 1'b1;
        end
    end

    assign o_stat_branches = br_q;
    assign o_stat_mispred  = mp_q;
`else
    assign o_stat_branches = '0;
    assign o_stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a per-cycle reference model.
// Honours BRANCH_STATS_EN the same way the design does.
module tb_branch_resolve_ctrl;
    import branch_resolve_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_jump;
    logic        cmp_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_pc;
    logic        flush;
    logic        stall;
    logic [31:0] stat_br;
    logic [31:0] stat_mp;

    int n_chk  = 0;
    int n_fail = 0;

    branch_resolve_ctrl_if #(.XLEN(32)) rif ();

    branch_resolve_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_if_pc         (if_pc),
        .o_if_pred_taken (pred_taken),
        .i_ex_valid      (ex_valid),
        .i_ex_is_jump    (ex_is_jump),
        .i_cmp_branch    (cmp_branch),
        .i_ex_pc         (ex_pc),
        .i_ex_target     (ex_target),
        .i_ex_pred_pc    (ex_pred_pc),
        .redir           (rif),
        .o_flush         (flush),
        .o_stall         (stall),
        .o_stat_branches (stat_br),
        .o_stat_mispred  (stat_mp)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: redirect pending flag, fresh-redirect flag, counters.
    int          m_bht [64];
    bit          m_pend;
    bit          m_fresh;
    bit   [31:0] m_pc;
    int unsigned m_br;
    int unsigned m_mp;

    function automatic int bidx(bit [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) m_bht[i] <= 1;
            m_pend  <= 1'b0;
            m_fresh <= 1'b0;
            m_pc    <= '0;
            m_br    <= 0;
            m_mp    <= 0;
        end else begin
            m_fresh <= 1'b0;
            if (m_pend) begin
                if (rif.i_redirect_ready) m_pend <= 1'b0;
            end else if (ex_valid) begin
                bit        tk;
                bit [31:0] nx;
                int        k;
                tk = ex_is_jump || cmp_branch;
                nx = tk ? ex_target : ex_pc + 32'd4;
                m_br <= m_br + 1;
                if (nx != ex_pred_pc) begin
                    m_pend  <= 1'b1;
                    m_fresh <= 1'b1;
                    m_pc    <= nx;
                    m_mp    <= m_mp + 1;
                end
                if (!ex_is_jump) begin
                    k = m_bht[bidx(ex_pc)];
                    if (cmp_branch) k = (k < 3) ? k + 1 : 3;
                    else            k = (k > 0) ? k - 1 : 0;
                    m_bht[bidx(ex_pc)] <= k;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("pred_taken", 64'(pred_taken), 64'(m_bht[bidx(if_pc)] >= 2));
            chk("redirect_valid", 64'(rif.o_redirect_valid), 64'(m_pend));
            if (m_pend) chk("redirect_pc", 64'(rif.o_redirect_pc), 64'(m_pc));
            chk("flush", 64'(flush), 64'(m_fresh));
            chk("stall", 64'(stall), 64'(m_pend));
`ifdef BRANCH_STATS_EN
            chk("stat_branches", 64'(stat_br), 64'(m_br));
            chk("stat_mispred", 64'(stat_mp), 64'(m_mp));
`else
            chk("stat_branches", 64'(stat_br), 64'd0);
            chk("stat_mispred", 64'(stat_mp), 64'd0);
`endif
        end
    end

    task automatic resolve(input bit jmp, input bit cmp,
                           input bit [31:0] pc, input bit [31:0] tgt,
                           input bit [31:0] pred);
        @(posedge clk); #1;
        ex_valid   = 1'b1;
        ex_is_jump = jmp;
        cmp_branch = cmp;
        ex_pc      = pc;
        ex_target  = tgt;
        ex_pred_pc = pred;
        @(posedge clk); #1;
        ex_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        if_pc      = 32'h100;
        ex_valid   = 1'b0;
        ex_is_jump = 1'b0;
        cmp_branch = 1'b0;
        ex_pc      = '0;
        ex_target  = '0;
        ex_pred_pc = '0;
        rif.i_redirect_ready = 1'b1;
        idle(2);
        chk("rst pred_taken", 64'(pred_taken), 64'd0);
        chk("rst valid", 64'(rif.o_redirect_valid), 64'd0);
        chk("rst pc", 64'(rif.o_redirect_pc), 64'd0);
        chk("rst flush", 64'(flush), 64'd0);
        chk("rst stall", 64'(stall), 64'd0);
        chk("rst stats", 64'({stat_br, stat_mp}), 64'd0);
        rst = 1'b0;
        idle(1);

        // Taken branch predicted not-taken
        resolve(0, 1, 32'h100, 32'h200, 32'h104);
        chk("t2 valid", 64'(rif.o_redirect_valid), 64'd1);
        chk("t2 pc", 64'(rif.o_redirect_pc), 64'h200);
        chk("t2 flush", 64'(flush), 64'd1);
        chk("t2 bht 10", 64'(pred_taken), 64'd1);
        idle(2);

        // Same with fetch back-pressure for 3 cycles
        rif.i_redirect_ready = 1'b0;
        resolve(0, 1, 32'h100, 32'h200, 32'h104);
        chk("t3 flush first", 64'(flush), 64'd1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("t3 hold valid", 64'(rif.o_redirect_valid), 64'd1);
            chk("t3 hold pc", 64'(rif.o_redirect_pc), 64'h200);
            chk("t3 hold stall", 64'(stall), 64'd1);
            chk("t3 no flush", 64'(flush), 64'd0);
        end
        rif.i_redirect_ready = 1'b1;
        idle(1);
        chk("t3 released", 64'({rif.o_redirect_valid, stall}), 64'd0);

        // Drive counter down to 00 and past it
        for (int i = 0; i < 4; i++) resolve(0, 0, 32'h100, 32'h200, 32'h104);
        chk("t4 no stall", 64'(stall), 64'd0);
        chk("t4 no redirect", 64'(rif.o_redirect_valid), 64'd0);
        chk("t4 bht 00", 64'(pred_taken), 64'd0);
        resolve(0, 1, 32'h100, 32'h200, 32'h200);
        chk("t4 sat 00->01", 64'(pred_taken), 64'd0);
        resolve(0, 1, 32'h100, 32'h200, 32'h200);
        chk("t4 01->10", 64'(pred_taken), 64'd1);

        // Jump, then wrap-around fall-through
        if_pc = 32'h3FC;
        resolve(1, 0, 32'h3FC, 32'h0, 32'h400);
        chk("t5 jump pc", 64'(rif.o_redirect_pc), 64'h0);
        chk("t5 jump valid", 64'(rif.o_redirect_valid), 64'd1);
        chk("t5 bht unchanged", 64'(pred_taken), 64'd0);
        idle(2);
        resolve(0, 0, 32'hFFFF_FFFC, 32'h50, 32'h8);
        chk("t5 wrap pc", 64'(rif.o_redirect_pc), 64'h0);
        chk("t5 wrap valid", 64'(rif.o_redirect_valid), 64'd1);
        idle(2);

        // Reset in the middle of a pending redirect
        rif.i_redirect_ready = 1'b0;
        if_pc = 32'h100;
        resolve(0, 1, 32'h100, 32'h200, 32'h104);
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 async valid", 64'(rif.o_redirect_valid), 64'd0);
        chk("t6 async stall", 64'(stall), 64'd0);
        chk("t6 async flush", 64'(flush), 64'd0);
        chk("t6 async stats", 64'({stat_br, stat_mp}), 64'd0);
        chk("t6 async bht", 64'(pred_taken), 64'd0);
        idle(1);
        rst = 1'b0;
        rif.i_redirect_ready = 1'b1;
        resolve(0, 1, 32'h40, 32'h80, 32'h44);
        chk("t6 redirect", 64'(rif.o_redirect_pc), 64'h80);
        idle(2);
        resolve(0, 0, 32'h40, 32'h80, 32'h44);
        idle(1);
`ifdef BRANCH_STATS_EN
        chk("t6 branches", 64'(stat_br), 64'd2);
        chk("t6 mispred", 64'(stat_mp), 64'd1);
`else
        chk("t6 branches", 64'(stat_br), 64'd0);
        chk("t6 mispred", 64'(stat_mp), 64'd0);
`endif
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
